regfile_wb_arbiter: RTL and testbench

//   Arbitrates two writeback requesters onto the single write port of the 32x64 register file.

---
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: two requesters (0 = ALU, 1 = load) presenting rd/data
// toward the register-file write arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64
);
  // Handshake: a transfer happens on a rising edge where valid && ready. The
  // requester keeps valid, rd and data stable until then; ready is combinational.
  logic              req0_valid;
  logic [4:0]        req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [4:0]        req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter of ALU/load writeback onto the single register-file write
// port, with registered write stage, x0 write suppression and RAW hazard flags.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave wb,
  input  logic [4:0]          RS1,
  input  logic [4:0]          RS2,
  output logic                stall_rs1,
  output logic                stall_rs2,
  output logic                RegWrite,
  output logic [4:0]          RD,
  output logic [DATA_W-1:0]   WriteData,
  output logic [CNT_W-1:0]    cnt0,
  output logic [CNT_W-1:0]    cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_rr_last;
  logic              r_regwrite;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic              w_grant0;
  logic              w_grant1;
  logic [4:0]        w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_stall_rs1;
  logic              w_stall_rs2;

  // Contention goes to whoever did not win last; nothing is granted in reset.
  always_comb begin
    w_grant0   = 1'b0;
    w_grant1   = 1'b0;
    w_sel_rd   = wb.req0_rd;
    w_sel_data = wb.req0_data;
    if (!reset) begin
      w_grant0 = wb.req0_valid && (!wb.req1_valid || r_rr_last);
      w_grant1 = wb.req1_valid && (!wb.req0_valid || !r_rr_last);
    end
    if (w_grant1) begin
      w_sel_rd   = wb.req1_rd;
      w_sel_data = wb.req1_data;
    end
  end

  always_comb begin
    w_stall_rs1 = (RS1 != 5'd0) &&
                  ((wb.req0_valid && (wb.req0_rd == RS1)) ||
                   (wb.req1_valid && (wb.req1_rd == RS1)) ||
                   (r_regwrite && (r_rd == RS1)));
    w_stall_rs2 = (RS2 != 5'd0) &&
                  ((wb.req0_valid && (wb.req0_rd == RS2)) ||
                   (wb.req1_valid && (wb.req1_rd == RS2)) ||
                   (r_regwrite && (r_rd == RS2)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_last  <= 1'b1;
      r_regwrite <= 1'b0;
      r_rd       <= 5'd0;
      r_wdata    <= '0;
      r_cnt0     <= '0;
      r_cnt1     <= '0;
    end else begin
      r_regwrite <= 1'b0;
      if (w_grant0 || w_grant1) begin
        r_rr_last <= w_grant1;
        // x0 transfers complete but leave RD/WriteData untouched.
        if (w_sel_rd != 5'd0) begin
          r_regwrite <= 1'b1;
          r_rd       <= w_sel_rd;
          r_wdata    <= w_sel_data;
        end
      end
      if (w_grant0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_ONE;
      if (w_grant1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_ONE;
    end
  end

  assign wb.req0_ready = w_grant0;
  assign wb.req1_ready = w_grant1;
  assign stall_rs1     = w_stall_rs1;
  assign stall_rs2     = w_stall_rs2;
  assign RegWrite      = r_regwrite;
  assign RD            = r_rd;
  assign WriteData     = r_wdata;
  assign cnt0          = r_cnt0;
  assign cnt1          = r_cnt1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, randomized run against a
// queue-based reference model, and a counter-saturation/mid-transfer reset sequence.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;
  logic [4:0] rs1;
  logic [4:0] rs2;

  logic        stall1, stall2, regwrite;
  logic [4:0]  rd_o;
  logic [63:0] wdata;
  logic [15:0] c0, c1;

  logic        s_stall1, s_stall2, s_regwrite;
  logic [4:0]  s_rd;
  logic [63:0] s_wdata;
  logic [1:0]  s_c0, s_c1;

  regfile_wb_arbiter_if #(.DATA_W(64)) wb_if ();
  regfile_wb_arbiter_if #(.DATA_W(64)) wb2_if ();

  // The narrow-counter instance sees the same requests as the main one.
  assign wb2_if.req0_valid = wb_if.req0_valid;
  assign wb2_if.req0_rd    = wb_if.req0_rd;
  assign wb2_if.req0_data  = wb_if.req0_data;
  assign wb2_if.req1_valid = wb_if.req1_valid;
  assign wb2_if.req1_rd    = wb_if.req1_rd;
  assign wb2_if.req1_data  = wb_if.req1_data;

  regfile_wb_arbiter #(.DATA_W(64), .CNT_W(16)) dut (
    .clk(clk), .reset(rst), .wb(wb_if), .RS1(rs1), .RS2(rs2),
    .stall_rs1(stall1), .stall_rs2(stall2), .RegWrite(regwrite),
    .RD(rd_o), .WriteData(wdata), .cnt0(c0), .cnt1(c1)
  );

  regfile_wb_arbiter #(.DATA_W(64), .CNT_W(2)) dut_small (
    .clk(clk), .reset(rst), .wb(wb2_if), .RS1(rs1), .RS2(rs2),
    .stall_rs1(s_stall1), .stall_rs2(s_stall2), .RegWrite(s_regwrite),
    .RD(s_rd), .WriteData(s_wdata), .cnt0(s_c0), .cnt1(s_c1)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0; logic [4:0] rd0; logic [63:0] d0;
    logic        v1; logic [4:0] rd1; logic [63:0] d1;
    logic [4:0]  rs1; logic [4:0] rs2;
    logic        e_r0; logic e_r1; logic e_s1; logic e_s2;
    logic        e_wr; logic [4:0] e_rd; logic [63:0] e_wd;
    int          e_c0; int e_c1;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // scoreboard: expected {rd, data} writes, in retirement order
  logic [68:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cap(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  // driver: apply one row, check combinational outputs mid-cycle and
  // registered outputs just after the following rising edge
  task automatic run_cycle(input vec_t v);
    @(negedge clk);
    rst = v.rst;
    wb_if.req0_valid = v.v0; wb_if.req0_rd = v.rd0; wb_if.req0_data = v.d0;
    wb_if.req1_valid = v.v1; wb_if.req1_rd = v.rd1; wb_if.req1_data = v.d1;
    rs1 = v.rs1; rs2 = v.rs2;
    #1;
    chk("ready0", {63'd0, wb_if.req0_ready}, {63'd0, v.e_r0});
    chk("ready1", {63'd0, wb_if.req1_ready}, {63'd0, v.e_r1});
    chk("stall_rs1", {63'd0, stall1}, {63'd0, v.e_s1});
    chk("stall_rs2", {63'd0, stall2}, {63'd0, v.e_s2});
    @(posedge clk);
    #1;
    chk("RegWrite", {63'd0, regwrite}, {63'd0, v.e_wr});
    chk("RD", {59'd0, rd_o}, {59'd0, v.e_rd});
    chk("WriteData", wdata, v.e_wd);
    chk("cnt0", {48'd0, c0}, 64'(v.e_c0));
    chk("cnt1", {48'd0, c1}, 64'(v.e_c1));
    chk("cnt0_w2", {62'd0, s_c0}, 64'(cap(v.e_c0, 3)));
    chk("cnt1_w2", {62'd0, s_c1}, 64'(cap(v.e_c1, 3)));
  endtask

  vec_t tbl[14];

  // reference model state
  int          m_last;
  logic        m_wr;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  int          m_c0, m_c1, m_c0s, m_c1s;

  initial begin
    vec_t v;
    logic g0, g1;
    logic [68:0] e;
    rst = 1'b1; rs1 = 0; rs2 = 0;
    wb_if.req0_valid = 0; wb_if.req0_rd = 0; wb_if.req0_data = 0;
    wb_if.req1_valid = 0; wb_if.req1_rd = 0; wb_if.req1_data = 0;

    //          rst v0 rd0 d0          v1 rd1 d1       rs1 rs2 r0 r1 s1 s2 wr rd wd          c0 c1
    tbl[0]  = '{1, 1, 1, 64'h11,     1, 2, 64'h22, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,      0, 0};
    tbl[1]  = '{1, 1, 1, 64'h11,     1, 2, 64'h22, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,      0, 0};
    tbl[2]  = '{0, 1, 1, 64'h11,     1, 2, 64'h22, 0, 0, 1, 0, 0, 0, 1, 1, 64'h11,     1, 0};
    tbl[3]  = '{0, 1, 1, 64'h11,     1, 2, 64'h22, 1, 2, 0, 1, 1, 1, 1, 2, 64'h22,     1, 1};
    tbl[4]  = '{0, 1, 1, 64'h11,     1, 2, 64'h22, 0, 0, 1, 0, 0, 0, 1, 1, 64'h11,     2, 1};
    tbl[5]  = '{0, 1, 1, 64'h11,     1, 2, 64'h22, 0, 0, 0, 1, 0, 0, 1, 2, 64'h22,     2, 2};
    tbl[6]  = '{0, 1, 5, 64'hDEAD,   0, 0, 64'h0,  2, 5, 1, 0, 1, 1, 1, 5, 64'hDEAD,   3, 2};
    tbl[7]  = '{0, 0, 0, 64'h0,      0, 0, 64'h0,  5, 2, 0, 0, 1, 0, 0, 5, 64'hDEAD,   3, 2};
    tbl[8]  = '{0, 0, 0, 64'h0,      1, 0, 64'hFF, 0, 0, 0, 1, 0, 0, 0, 5, 64'hDEAD,   3, 3};
    tbl[9]  = '{0, 0, 0, 64'h0,      1, 7, 64'h77, 7, 0, 0, 1, 1, 0, 1, 7, 64'h77,     3, 4};
    tbl[10] = '{0, 0, 0, 64'h0,      0, 0, 64'h0,  7, 0, 0, 0, 1, 0, 0, 7, 64'h77,     3, 4};
    tbl[11] = '{0, 0, 0, 64'h0,      0, 0, 64'h0,  7, 0, 0, 0, 0, 0, 0, 7, 64'h77,     3, 4};
    tbl[12] = '{0, 1, 0, 64'h5,      0, 0, 64'h0,  0, 0, 1, 0, 0, 0, 0, 7, 64'h77,     4, 4};
    tbl[13] = '{1, 1, 3, 64'h9,      0, 0, 64'h0,  3, 0, 0, 0, 1, 0, 0, 0, 64'h0,      0, 0};

    for (int i = 0; i < 14; i++) run_cycle(tbl[i]);

    // randomized run: requesters hold until accepted, occasional reset
    m_last = 1; m_wr = 0; m_rd = 0; m_data = 0;
    m_c0 = 0; m_c1 = 0; m_c0s = 0; m_c1s = 0;
    v = tbl[13];
    v.v0 = 0; v.v1 = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v.rst = (cyc < 2) || ($urandom_range(0, 59) == 0);
      if (!v.v0 && $urandom_range(0, 3) != 0) begin
        v.v0 = 1; v.rd0 = 5'($urandom_range(0, 7)); v.d0 = {$urandom, $urandom};
      end
      if (!v.v1 && $urandom_range(0, 3) != 0) begin
        v.v1 = 1; v.rd1 = 5'($urandom_range(0, 7)); v.d1 = {$urandom, $urandom};
      end
      v.rs1 = 5'($urandom_range(0, 7));
      v.rs2 = 5'($urandom_range(0, 7));

      g0 = !v.rst && v.v0 && (!v.v1 || m_last == 1);
      g1 = !v.rst && v.v1 && (!v.v0 || m_last == 0);
      v.e_r0 = g0; v.e_r1 = g1;
      v.e_s1 = (v.rs1 != 0) && ((v.v0 && v.rd0 == v.rs1) || (v.v1 && v.rd1 == v.rs1) ||
                                (m_wr && m_rd == v.rs1));
      v.e_s2 = (v.rs2 != 0) && ((v.v0 && v.rd0 == v.rs2) || (v.v1 && v.rd1 == v.rs2) ||
                                (m_wr && m_rd == v.rs2));

      if (v.rst) begin
        exp_q.delete();
        m_last = 1; m_rd = 0; m_data = 0;
        m_c0 = 0; m_c1 = 0; m_c0s = 0; m_c1s = 0;
      end else if (g0) begin
        m_last = 0; m_c0 = cap(m_c0 + 1, 65535); m_c0s = cap(m_c0s + 1, 3);
        if (v.rd0 != 0) exp_q.push_back({v.rd0, v.d0});
      end else if (g1) begin
        m_last = 1; m_c1 = cap(m_c1 + 1, 65535); m_c1s = cap(m_c1s + 1, 3);
        if (v.rd1 != 0) exp_q.push_back({v.rd1, v.d1});
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_wr = 1; m_rd = e[68:64]; m_data = e[63:0];
      end else begin
        m_wr = 0;
      end
      v.e_wr = m_wr; v.e_rd = m_rd; v.e_wd = m_data;
      v.e_c0 = m_c0; v.e_c1 = m_c1;
      run_cycle(v);
      if (g0) v.v0 = 0;
      if (g1) v.v1 = 0;
    end

    // narrow counters: six back-to-back req0 transfers, then reset mid-transfer
    @(negedge clk);
    rst = 1; wb_if.req0_valid = 0; wb_if.req1_valid = 0; rs1 = 0; rs2 = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      wb_if.req0_valid = 1; wb_if.req0_rd = 5'd3; wb_if.req0_data = 64'(i + 100);
      #1;
      chk("sat_ready0", {63'd0, wb_if.req0_ready}, 64'd1);
      @(posedge clk);
      #1;
      chk("sat_cnt0_w2", {62'd0, s_c0}, 64'(cap(i + 1, 3)));
      chk("sat_cnt0", {48'd0, c0}, 64'(i + 1));
      chk("sat_regwrite", {63'd0, s_regwrite}, 64'd1);
      chk("sat_wdata", s_wdata, 64'(i + 100));
      @(negedge clk);
    end
    rst = 1;
    wb_if.req0_valid = 1; wb_if.req0_rd = 5'd4; wb_if.req0_data = 64'hBEEF;
    #1;
    chk("rst_ready0", {63'd0, wb_if.req0_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_regwrite", {63'd0, s_regwrite}, 64'd0);
    chk("rst_cnt0_w2", {62'd0, s_c0}, 64'd0);
    chk("rst_cnt0", {48'd0, c0}, 64'd0);
    chk("rst_rd", {59'd0, rd_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
